// File: rtl/dmem_pkg.sv
// Shared types and funct3 legality helpers for the data-memory arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic load_f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic store_f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way grant selector; prio1 gives port 1 the win on contention.
module dmem_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic en,
   input  logic prio1,
   output logic gnt0,
   output logic gnt1
);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (req0 && req1) begin
            gnt0 = ~prio1;
            gnt1 = prio1;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter and sequencer for the single-port datamemory.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [2:0]            funct3_0,
   input  logic [DM_ADDRESS-1:0] addr0,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [2:0]            funct3_1,
   input  logic [DM_ADDRESS-1:0] addr1,
   input  logic [DATA_W-1:0]     wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic                  err0,
   output logic                  err1,
   output logic [DATA_W-1:0]     rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [2:0]            mem_funct3,
   output logic [DM_ADDRESS-1:0] mem_a,
   output logic [DATA_W-1:0]     mem_wd,
   input  logic [DATA_W-1:0]     mem_rd
);

   arb_state_t state;
   logic       owner;
   logic       we_q;
   logic       err_q;
   logic       prio1;
   logic       accept;
   logic       pick_en;

   logic                  sel_we;
   logic [2:0]            sel_f3;
   logic [DM_ADDRESS-1:0] sel_addr;
   logic [DATA_W-1:0]     sel_wd;
   logic                  sel_legal;

   // Grants are ready signals; held low while reset is asserted.
   assign pick_en = rst_n && (state == IDLE || state == RESP);

   dmem_arb_pick u_pick (
      .req0  (req0),
      .req1  (req1),
      .en    (pick_en),
      .prio1 (prio1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   assign accept = gnt0 | gnt1;

`ifdef DMEM_ARB_RR_EN
   logic last_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt <= 1'b1;
      else if (accept)
         last_gnt <= gnt1;
   end

   assign prio1 = ~last_gnt;
`else
   assign prio1 = 1'b0;
`endif

   assign sel_we    = gnt1 ? we1      : we0;
   assign sel_f3    = gnt1 ? funct3_1 : funct3_0;
   assign sel_addr  = gnt1 ? addr1    : addr0;
   assign sel_wd    = gnt1 ? wdata1   : wdata0;
   assign sel_legal = sel_we ? store_f3_legal(sel_f3) : load_f3_legal(sel_f3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata      <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_funct3 <= '0;
         mem_a      <= '0;
         mem_wd     <= '0;
      end else begin
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_funct3 <= '0;
         mem_a      <= '0;
         mem_wd     <= '0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  owner <= gnt1;
                  we_q  <= sel_we;
                  err_q <= ~sel_legal;
                  // Illegal requests never touch the memory bus.
                  if (sel_legal) begin
                     mem_read   <= ~sel_we;
                     mem_write  <= sel_we;
                     mem_funct3 <= sel_f3;
                     mem_a      <= sel_addr;
                     mem_wd     <= sel_wd;
                  end
                  state <= ACCESS;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               if (owner) begin
                  rvalid1 <= 1'b1;
                  err1    <= err_q;
               end else begin
                  rvalid0 <= 1'b1;
                  err0    <= err_q;
               end
               if (!we_q && !err_q)
                  rdata <= mem_rd;
               state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural datamemory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [2:0]  funct3_0, funct3_1;
   logic [8:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata;
   logic        mem_read, mem_write;
   logic [2:0]  mem_funct3;
   logic [8:0]  mem_a;
   logic [31:0] mem_wd, mem_rd;

   logic [31:0] bmem [512];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .funct3_0(funct3_0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .funct3_1(funct3_1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .err0(err0), .err1(err1), .rdata(rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // datamemory stand-in: combinational read, write on the edge leaving ACCESS
   assign mem_rd = bmem[mem_a];
   always @(posedge clk) if (mem_write) bmem[mem_a] <= mem_wd;

   typedef struct {
      logic r0, w0; logic [2:0] f0; logic [8:0] a0; logic [31:0] d0;
      logic r1, w1; logic [2:0] f1; logic [8:0] a1; logic [31:0] d1;
      logic [7:0] flags;  // {gnt0,gnt1,rvalid0,rvalid1,err0,err1,mem_read,mem_write}
      logic [8:0] ea;
      logic [31:0] erd;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(input logic r0, input logic w0, input logic [2:0] f0,
                               input logic [8:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [2:0] f1,
                               input logic [8:0] a1, input logic [31:0] d1,
                               input logic [7:0] flags, input logic [8:0] ea,
                               input logic [31:0] erd);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.f0 = f0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.f1 = f1; v.a1 = a1; v.d1 = d1;
      v.flags = flags; v.ea = ea; v.erd = erd;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req0 = 0; we0 = 0; funct3_0 = 3'b010; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; funct3_1 = 3'b010; addr1 = '0; wdata1 = '0;
   endtask

   function automatic logic [7:0] flags_now();
      return {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write};
   endfunction

   localparam logic [7:0] NONE = 8'b0;
   int order [4];
   int ng;
   logic seen_rv;

   initial begin
      for (int i = 0; i < 512; i++) bmem[i] = 32'hA000_0000 | i;
      idle_inputs();

      vecs[0]  = mk(1,1,3'b010,9'd5,32'hDEADBEEF, 0,0,3'b010,9'd0,32'h0, 8'b10000000, 9'd0, 32'h0);
      vecs[1]  = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00000001, 9'd5, 32'h0);
      vecs[2]  = mk(1,0,3'b010,9'd5,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b10100000, 9'd0, 32'h0);
      vecs[3]  = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00000010, 9'd5, 32'h0);
      vecs[4]  = mk(0,0,3'b010,9'd0,32'h0,        1,0,3'b011,9'd9,32'h0, 8'b01100000, 9'd0, 32'hDEADBEEF);
      vecs[5]  = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, NONE,        9'd0, 32'hDEADBEEF);
      vecs[6]  = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00010100, 9'd0, 32'hDEADBEEF);
      vecs[7]  = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, NONE,        9'd0, 32'hDEADBEEF);
      vecs[8]  = mk(0,0,3'b010,9'd0,32'h0,        1,1,3'b011,9'd3,32'h55, 8'b01000000, 9'd0, 32'hDEADBEEF);
      vecs[9]  = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, NONE,        9'd0, 32'hDEADBEEF);
      vecs[10] = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00010100, 9'd0, 32'hDEADBEEF);
      vecs[11] = mk(0,0,3'b010,9'd0,32'h0,        1,0,3'b100,9'd5,32'h0, 8'b01000000, 9'd0, 32'hDEADBEEF);
      vecs[12] = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00000010, 9'd5, 32'hDEADBEEF);
      vecs[13] = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00010000, 9'd0, 32'hDEADBEEF);
      vecs[14] = mk(1,0,3'b010,9'd1,32'h0,        1,0,3'b010,9'd2,32'h0, 8'b10000000, 9'd0, 32'hDEADBEEF);
      vecs[15] = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00000010, 9'd1, 32'hDEADBEEF);
      vecs[16] = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, 8'b00100000, 9'd0, 32'hA0000001);
      vecs[17] = mk(0,0,3'b010,9'd0,32'h0,        0,0,3'b010,9'd0,32'h0, NONE,        9'd0, 32'hA0000001);

      // Reset with req0 held high: everything quiet, then gnt0 right after release
      rst_n = 1'b0;
      req0 = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("reset_flags", 64'(flags_now()), 64'(NONE));
      check("reset_bus", {mem_funct3, mem_a, mem_wd}, 64'h0);
      check("reset_rdata", 64'(rdata), 64'h0);
      #1 rst_n = 1'b1;
      #1 check("gnt0_after_reset", 64'(gnt0), 64'h1);
      req0 = 1'b0;

      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         req0 = vecs[i].r0; we0 = vecs[i].w0; funct3_0 = vecs[i].f0;
         addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
         req1 = vecs[i].r1; we1 = vecs[i].w1; funct3_1 = vecs[i].f1;
         addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
         #1;
         check($sformatf("vec%0d", i), {flags_now(), 7'b0, mem_a, rdata, 8'b0},
               {vecs[i].flags, 7'b0, vecs[i].ea, vecs[i].erd, 8'b0});
         if (i == 1) check("vec1_wd", 64'(mem_wd), 64'hDEADBEEF);
      end

      // Contention: both ports hold requests for four grants, starting from reset
      @(posedge clk);
      #1 rst_n = 1'b0;
      idle_inputs();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      req0 = 1; addr0 = 9'd0; req1 = 1; addr1 = 9'd0;
      ng = 0;
      for (int c = 0; c < 20 && ng < 4; c++) begin
         #1;
         if (gnt0 && gnt1) check("single_gnt", 64'({gnt0, gnt1}), 64'h1);
         else if (gnt0 || gnt1) begin
            order[ng] = gnt1 ? 1 : 0;
            ng++;
         end
         @(posedge clk);
         #1;
      end
      idle_inputs();
      check("contention_grants", 64'(ng), 64'd4);
`ifdef DMEM_ARB_RR_EN
      check("grant_order", {32'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])},
            {32'd0, 8'd1, 8'd0, 8'd1});
`else
      check("grant_order", {32'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])},
            {32'd0, 8'd0, 8'd0, 8'd0});
`endif
      repeat (3) @(posedge clk);

      // Reset during the ACCESS of sw addr 7: write dropped, no response
      #1;
      req0 = 1; we0 = 1; funct3_0 = 3'b010; addr0 = 9'd7; wdata0 = 32'h1;
      #1 check("sw7_gnt", 64'(gnt0), 64'h1);
      @(posedge clk);
      #1 idle_inputs();
      #1 check("sw7_access", 64'({mem_write, mem_a}), 64'({1'b1, 9'd7}));
      rst_n = 1'b0;
      #1 check("sw7_abort_bus", 64'({mem_write, mem_a}), 64'h0);
      seen_rv = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #2 if (rvalid0 || rvalid1) seen_rv = 1'b1;
      end
      rst_n = 1'b1;
      @(posedge clk);
      #2 if (rvalid0 || rvalid1) seen_rv = 1'b1;
      check("abort_no_rvalid", 64'(seen_rv), 64'h0);

      #1;
      req0 = 1; we0 = 0; funct3_0 = 3'b010; addr0 = 9'd7;
      #1 check("lw7_gnt", 64'(gnt0), 64'h1);
      @(posedge clk);
      #1 idle_inputs();
      @(posedge clk);
      #2 check("lw7_resp", {rvalid0, err0, 30'b0, rdata}, {1'b1, 1'b0, 30'b0, 32'hA0000007});

      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port `datamemory` data memory. It shares the memory between the pipeline MEM stage (port 0) and a loader/debug master (port 1) using a valid/ready request handshake. The access is registered, and each access returns a one-cycle response pulse. It sits between the MEM stage / loader and `datamemory`, and drives that module's MemRead, MemWrite, funct3, a and wd inputs.

## Interface
- DM_ADDRESS, 9, word-address width into data memory
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request valid, port 0 / port 1
- we0 / we1  in  1  1 = store, 0 = load
- funct3_0 / funct3_1  in  3  RISC-V load/store funct3
- addr0 / addr1  in  DM_ADDRESS  word address
- wdata0 / wdata1  in  DATA_W  store data
- gnt0 / gnt1  out  1  request accepted this cycle (ready)
- rvalid0 / rvalid1  out  1  one-cycle response pulse
- err0 / err1  out  1  qualifies rvalid: illegal funct3, no access done
- rdata  out  DATA_W  load data, valid with rvalid (shared by both ports)
- mem_read, mem_write  out  1  to MemRead / MemWrite
- mem_funct3  out  3  to funct3
- mem_a  out  DM_ADDRESS  to a
- mem_wd  out  DATA_W  to wd
- mem_rd  in  DATA_W  from rd (combinational read)

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Acceptance:
  - gnt may assert only in IDLE or RESP, and only when the owning req is high.
  - At most one gnt is high per cycle.
  - Acceptance is gnt & req on a rising edge.
- On acceptance:
  - Latch owner, we, funct3, addr and wdata.
  - Go to ACCESS.
- Legality check, done at acceptance:
  - Loads: funct3 must be in {000, 001, 010, 100, 101}.
  - Stores: funct3 must be in {000, 001, 010}.
  - An illegal request sets the latched err flag.
- ACCESS:
  - If err is clear, drive mem_read = ~we or mem_write = we, with mem_a, mem_funct3 and mem_wd taken from the latches.
  - On the same edge that leaves ACCESS:
    - `datamemory` performs the write.
    - The arbiter registers mem_rd into rdata on loads.
  - If err is set, mem_read and mem_write stay 0.
  - Next state is RESP.
- RESP:
  - rvalid of the owner is 1 for exactly this cycle.
  - err of the owner equals the latched flag.
  - rdata holds the load value. It is unchanged for stores and errors.
  - A new request may be granted in RESP, which goes to ACCESS. Otherwise the next state is IDLE.
- Arbitration is fixed priority by default: port 0 wins. See Configuration for round-robin.
- Outside ACCESS, the mem_* outputs are 0. This also holds after reset.

## Timing
- Request accepted at edge N → memory access in cycle N+1 → rvalid in cycle N+2.
- Sustained throughput: 1 access per 2 cycles per arbiter.
- A requester must hold req and its payload stable until it sees gnt. Dropping req before gnt is permitted and has no effect.
- Reset values of outputs:
  - gnt0/1, rvalid0/1, err0/1, mem_read, mem_write: 0.
  - mem_funct3, mem_a, mem_wd: 0.
  - rdata: 0.
- Reset mid-operation: the FSM returns to IDLE immediately.
  - A write in ACCESS that has not yet reached its edge is dropped.
  - No rvalid is issued for the aborted access.
- Simultaneous req0 and req1: exactly one gnt, per the arbitration rule. The loser keeps waiting with gnt low.
- Address wrap: none. Addresses are used as given, modulo 2^DM_ADDRESS.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit last-grant pointer, reset to port 1, gives priority to the port not granted last.
  - The pointer updates only on acceptance.
- Not defined: fixed priority with port 0 always winning. No pointer register.

## Structure
- Package `dmem_pkg`:
  - State enum `arb_state_t` {IDLE, ACCESS, RESP}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Functions `load_f3_legal` and `store_f3_legal`.
- One sub-module, `dmem_arb_pick`: a combinational 2-way grant selector that takes req0, req1, an enable and the priority pointer.

## Test plan
- Reset with req0 held high → all outputs 0. After rst_n rises, gnt0 = 1 in the first cycle.
- Port 0 sw addr 5, data 0xDEADBEEF, then lw addr 5 → rvalid0 at N+2 for both. Load rdata = 0xDEADBEEF, err0 = 0.
- req0 and req1 both held for 4 grants:
  - Fixed priority: grants are 0, 0, 0, 0.
  - With `DMEM_ARB_RR_EN`: grants are 0, 1, 0, 1.
- Port 1 load with funct3 = 011 → mem_read stays 0. rvalid1 = err1 = 1 at N+2, rdata unchanged.
- rst_n asserted during the ACCESS of sw addr 7, data 0x1 → no rvalid. A later lw addr 7 returns the prior contents.
- Back-to-back: new req0 presented in RESP → gnt0 in RESP. Accesses occur every 2 cycles with no idle cycle.
